bram_rd_sched_qpsk: RTL and testbench
=====================================

BRAM_RD_SCHED_QPSK -- requirements
Module: bram_rd_sched_qpsk

Interface
REQ-001 Parameter DEPTH, 10000: symbols stored per port region.
REQ-002 Parameter B_BASE, 10000: port-B region base address.
REQ-003 Parameter RD_LAT, 2: BRAM read latency in clocks (address/en to data).
REQ-004 Parameter ADDR_W, 15 / DATA_W, 12: address and sample widths.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 bram_wr_done  in  1  level; BRAM fully loaded by the write controller.
REQ-008 play_start  in  1  one-cycle start request.
REQ-009 play_stop  in  1  one-cycle abort request.
REQ-010 loop_en  in  1  wrap to index 0 after DEPTH-1 instead of finishing.
REQ-011 rate_div  in  8  symbol period minus 1, in clocks.
REQ-012 ram_rd_data_a / ram_rd_data_b  in  DATA_W each  BRAM read data (I / Q).
REQ-013 ram_addr_a / ram_addr_b  out  ADDR_W each  BRAM read addresses.
REQ-014 bram_en  out  1  BRAM enable, one-cycle pulse per read.
REQ-015 bram_wea  out  1  write enable, always 0 from this block.
REQ-016 sym_i / sym_q  out  DATA_W each  registered symbol outputs.
REQ-017 sym_valid  out  1  one-cycle strobe, sym_i/sym_q valid.
REQ-018 busy  out  1  high in RUN and DRAIN.
REQ-019 play_done  out  1  one-cycle pulse at completion or abort.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-021 IDLE->RUN when play_start=1, play_stop=0, bram_wr_done=1; otherwise play_start ignored.
REQ-022 On IDLE->RUN: index cleared to 0, rate_div latched into rate_q, rate counter cleared.
REQ-023 RUN: rate counter counts 0..rate_q; read issued in cycles where counter==0, first read in the first RUN cycle.
REQ-024 Read issue: bram_en=1 for one cycle, ram_addr_a=index, ram_addr_b=B_BASE+index, both registered with bram_en.
REQ-025 After each issue index increments; issue at index DEPTH-1: loop_en=1 -> index 0, stay RUN; loop_en=0 -> DRAIN.
REQ-026 rate_q=0 gives a read every clock; rate_q=N gives one read every N+1 clocks.
REQ-027 play_stop in RUN -> DRAIN next cycle, no further issue; stop coincident with an issue: that issue completes.
REQ-028 Issue pipeline: RD_LAT-deep valid shift register; at its output sym_i<=ram_rd_data_a, sym_q<=ram_rd_data_b, sym_valid=1 for one cycle, exactly RD_LAT+1 clocks after the bram_en pulse.
REQ-029 Every issued read produces exactly one sym_valid, including reads in flight at stop.
REQ-030 DRAIN: stay until valid shift register empty, then DONE; DONE asserts play_done for one cycle -> IDLE.
REQ-031 play_start while busy ignored; play_stop in IDLE/DONE ignored.
REQ-032 Addresses hold last value when not issuing; sym_i/sym_q hold last value.
REQ-033 Index width ADDR_W; B_BASE+index never exceeds 2^ADDR_W-1 (19999 max).

Reset
REQ-034 rst_n low: state IDLE, index 0, rate_q 0, counter 0, shift register 0.
REQ-035 Reset outputs: ram_addr_a 0, ram_addr_b B_BASE, bram_en 0, bram_wea 0, sym_i/sym_q 0, sym_valid 0, busy 0, play_done 0.
REQ-036 Reset mid-RUN/DRAIN aborts immediately; no play_done and no sym_valid after reset asserts.

Structure
REQ-037 DEPTH, B_BASE, RD_LAT, ADDR_W, DATA_W and the FSM state encoding live in shared package qpsk_bram_pkg, shared with the write controller.
REQ-038 One sub-module: rd_lat_pipe (parameterised valid shift register with empty flag); all else inline.

Verification
REQ-039 wr_done=1, rate_div=0, loop_en=0, start -> 10000 bram_en pulses on consecutive clocks, addr_a 0..9999, addr_b 10000..19999, 10000 sym_valid, one play_done.
REQ-040 wr_done=0, start -> no bram_en, busy stays 0; then wr_done=1, start -> playback begins.
REQ-041 rate_div=3 -> bram_en spacing exactly 4 clocks; sym_valid exactly RD_LAT+1=3 clocks after each bram_en; data matches BRAM model at that address.
REQ-042 loop_en=1 -> after addr_a 9999 next issue addr_a 0/addr_b 10000, no play_done; stop later -> in-flight reads emitted, then play_done.
REQ-043 rate_div=0, play_stop coincident with issue at index 5 -> 6 sym_valid total, play_done 3 clocks later, busy falls with it.
REQ-044 rst_n low mid-RUN -> all outputs at reset values next edge, no play_done; start after release resumes from index 0.

Source files
------------

// File: rtl/qpsk_bram_pkg.sv
// Shared constants and FSM encoding for the QPSK BRAM write/read controllers.
package qpsk_bram_pkg;

    localparam int QPSK_DEPTH  = 10000;
    localparam int QPSK_B_BASE = 10000;
    localparam int QPSK_RD_LAT = 2;
    localparam int QPSK_ADDR_W = 15;
    localparam int QPSK_DATA_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid shift register tracking BRAM reads in flight.
module rd_lat_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic valid_o,
    output logic empty_o
);

    logic [LAT-1:0] sr_q, sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = valid_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign valid_o = sr_q[LAT-1];
    // Empty after this edge: only the output stage may still be emitting.
    assign empty_o = ~|sr_d;

endmodule

// File: rtl/bram_rd_sched_qpsk.sv
// BRAM read scheduler: paced I/Q symbol playback from two BRAM regions.
module bram_rd_sched_qpsk
    import qpsk_bram_pkg::*;
#(
    parameter int DEPTH  = QPSK_DEPTH,
    parameter int B_BASE = QPSK_B_BASE,
    parameter int RD_LAT = QPSK_RD_LAT,
    parameter int ADDR_W = QPSK_ADDR_W,
    parameter int DATA_W = QPSK_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bram_wr_done,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              loop_en,
    input  logic [7:0]        rate_div,
    input  logic [DATA_W-1:0] ram_rd_data_a,
    input  logic [DATA_W-1:0] ram_rd_data_b,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              bram_en,
    output logic              bram_wea,
    output logic [DATA_W-1:0] sym_i,
    output logic [DATA_W-1:0] sym_q,
    output logic              sym_valid,
    output logic              busy,
    output logic              play_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] B_OFS    = ADDR_W'(B_BASE);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        rate_q, rate_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] sym_i_q, sym_q_q;
    logic              sym_valid_q;
    logic              issue, last, pipe_out, pipe_empty;

    // en_q is precomputed so the enable is high in the issue cycle itself
    assign issue = en_q;
    assign last  = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (play_start && !play_stop && bram_wr_done) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    rate_d  = rate_div;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = (cnt_q == rate_q) ? '0 : cnt_q + 8'd1;
                if (issue) begin
                    idx_d = last ? '0 : idx_q + ADDR_W'(1);
                end
                if (play_stop || (issue && last && !loop_en)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        en_d     = (state_d == ST_RUN) && (cnt_d == '0);
        addr_a_d = en_d ? idx_d : addr_a_q;
        addr_b_d = en_d ? B_OFS + idx_d : addr_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rate_q   <= '0;
            cnt_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= B_OFS;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rate_q   <= rate_d;
            cnt_q    <= cnt_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            en_q     <= en_d;
        end
    end

    rd_lat_pipe #(
        .LAT(RD_LAT)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(en_q),
        .valid_o(pipe_out),
        .empty_o(pipe_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            sym_valid_q <= pipe_out;
            if (pipe_out) begin
                sym_i_q <= ram_rd_data_a;
                sym_q_q <= ram_rd_data_b;
            end
        end
    end

    assign ram_addr_a = addr_a_q;
    assign ram_addr_b = addr_b_q;
    assign bram_en    = en_q;
    assign bram_wea   = 1'b0;
    assign sym_i      = sym_i_q;
    assign sym_q      = sym_q_q;
    assign sym_valid  = sym_valid_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign play_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_rd_sched_qpsk.sv
// Directed bench for bram_rd_sched_qpsk with a 2-cycle BRAM model.
module tb_bram_rd_sched_qpsk;

    localparam int BB  = 10000;
    localparam int DEP = 10000;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bram_wr_done = 1'b0;
    logic        play_start = 1'b0;
    logic        play_stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [7:0]  rate_div = 8'd0;
    logic [11:0] ram_rd_data_a, ram_rd_data_b;
    logic [14:0] ram_addr_a, ram_addr_b;
    logic        bram_en, bram_wea;
    logic [11:0] sym_i, sym_q;
    logic        sym_valid, busy, play_done;

    always #5 clk = ~clk;

    bram_rd_sched_qpsk dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bram_wr_done (bram_wr_done),
        .play_start   (play_start),
        .play_stop    (play_stop),
        .loop_en      (loop_en),
        .rate_div     (rate_div),
        .ram_rd_data_a(ram_rd_data_a),
        .ram_rd_data_b(ram_rd_data_b),
        .ram_addr_a   (ram_addr_a),
        .ram_addr_b   (ram_addr_b),
        .bram_en      (bram_en),
        .bram_wea     (bram_wea),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .sym_valid    (sym_valid),
        .busy         (busy),
        .play_done    (play_done)
    );

    function automatic logic [11:0] fa(input int a);
        logic [31:0] t;
        t = a;
        return t[11:0] ^ 12'hA5C;
    endfunction

    function automatic logic [11:0] fb(input int a);
        logic [31:0] t;
        t = a * 7 + 3;
        return t[11:0];
    endfunction

    // BRAM model: data appears LAT clocks after the enable
    logic [11:0] d1a = '0, d1b = '0, d2a = '0, d2b = '0;
    always @(posedge clk) begin
        if (bram_en) begin
            d1a <= fa(int'(ram_addr_a));
            d1b <= fb(int'(ram_addr_b));
        end
        d2a <= d1a;
        d2b <= d1b;
    end
    assign ram_rd_data_a = d2a;
    assign ram_rd_data_b = d2b;

    typedef struct {
        int cyc;
        int addr;
    } rd_t;

    rd_t  q[$];
    logic mon_clr = 1'b0;
    int   gap_exp = 1;
    int   mcyc = 0, exp_idx = 0;
    int   en_cnt = 0, valid_cnt = 0, done_cnt = 0;
    int   addr_err = 0, gap_err = 0, lat_err = 0, busy_err = 0;
    int   rst_viol = 0, busy_seen = 0;
    int   last_en = 0, last_valid = 0, done_cyc = 0;

    always @(negedge clk) begin
        rd_t e;
        mcyc++;
        if (!rst_n && (bram_en || sym_valid || play_done)) rst_viol++;
        if (mon_clr || !rst_n) begin
            en_cnt = 0; valid_cnt = 0; done_cnt = 0;
            addr_err = 0; gap_err = 0; lat_err = 0; busy_err = 0;
            busy_seen = 0; exp_idx = 0;
            q.delete();
            if (mon_clr) rst_viol = 0;
        end else begin
            if (busy) busy_seen = 1;
            if (bram_en) begin
                if (int'(ram_addr_a) != exp_idx || int'(ram_addr_b) != BB + exp_idx)
                    addr_err++;
                if (en_cnt > 0 && mcyc - last_en != gap_exp) gap_err++;
                last_en = mcyc;
                en_cnt++;
                e.cyc = mcyc;
                e.addr = exp_idx;
                q.push_back(e);
                exp_idx = (exp_idx == DEP - 1) ? 0 : exp_idx + 1;
            end
            if (sym_valid) begin
                valid_cnt++;
                last_valid = mcyc;
                if (q.size() == 0) begin
                    lat_err++;
                end else begin
                    e = q.pop_front();
                    if (mcyc - e.cyc != LAT + 1 || sym_i != fa(e.addr) ||
                        sym_q != fb(BB + e.addr))
                        lat_err++;
                end
            end
            if (play_done) begin
                done_cnt++;
                done_cyc = mcyc;
                if (busy) busy_err++;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " addr_a"}, int'(ram_addr_a), 0);
        chk({tag, " addr_b"}, int'(ram_addr_b), BB);
        chk({tag, " bram_en"}, int'(bram_en), 0);
        chk({tag, " wea"}, int'(bram_wea), 0);
        chk({tag, " sym_i"}, int'(sym_i), 0);
        chk({tag, " sym_q"}, int'(sym_q), 0);
        chk({tag, " sym_valid"}, int'(sym_valid), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " play_done"}, int'(play_done), 0);
    endtask

    typedef struct {
        logic wr;
        int   rate;
        logic lp;
        int   stop_idx;
        int   hits;
        int   budget;
        int   exp_en;
        int   exp_valid;
        int   exp_done;
        int   exp_busy;
    } vec_t;

    vec_t vecs[6];
    vec_t v;
    int   hits, timeout, wait_ok;
    string tg;

    initial begin
        vecs[0] = '{1'b0, 0, 1'b0, -1, 0, 40, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 0, 1'b0, -1, 0, 10100, 10000, 10000, 1, 1};
        vecs[2] = '{1'b1, 3, 1'b0, 20, 1, 400, 21, 21, 1, 1};
        vecs[3] = '{1'b1, 0, 1'b0, 5, 1, 100, 6, 6, 1, 1};
        vecs[4] = '{1'b1, 0, 1'b1, 10, 2, 20200, 10011, 10011, 1, 1};
        vecs[5] = '{1'b1, 1, 1'b0, 7, 1, 100, 8, 8, 1, 1};

        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;

        // start together with stop, and stop alone in IDLE, are ignored
        bram_wr_done = 1'b1;
        clear_mon();
        @(negedge clk);
        play_start = 1'b1;
        play_stop = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
        repeat (3) @(negedge clk);
        play_stop = 1'b1;
        @(negedge clk);
        play_stop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("start+stop busy", busy_seen, 0);
        chk("start+stop en", en_cnt, 0);

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            tg = $sformatf("v%0d", k);
            bram_wr_done = v.wr;
            rate_div = 8'(v.rate);
            loop_en = v.lp;
            gap_exp = v.rate + 1;
            clear_mon();
            pulse_start();
            hits = 0;
            timeout = 1;
            for (int c = 0; c < v.budget; c++) begin
                @(negedge clk);
                play_stop = 1'b0;
                if (v.stop_idx >= 0 && bram_en && int'(ram_addr_a) == v.stop_idx) begin
                    hits++;
                    if (hits == v.hits) play_stop = 1'b1;
                end
                if (done_cnt > 0) begin
                    timeout = 0;
                    break;
                end
            end
            play_stop = 1'b0;
            if (v.exp_done > 0) chk({tg, " timeout"}, timeout, 0);
            repeat (6) @(negedge clk);
            #1;
            chk({tg, " en_cnt"}, en_cnt, v.exp_en);
            chk({tg, " valid_cnt"}, valid_cnt, v.exp_valid);
            chk({tg, " done_cnt"}, done_cnt, v.exp_done);
            chk({tg, " busy_seen"}, busy_seen, v.exp_busy);
            chk({tg, " addr_err"}, addr_err, 0);
            chk({tg, " gap_err"}, gap_err, 0);
            chk({tg, " lat_err"}, lat_err, 0);
            chk({tg, " busy_at_done"}, busy_err, 0);
            chk({tg, " busy_end"}, int'(busy), 0);
            chk({tg, " wea"}, int'(bram_wea), 0);
            if (v.exp_done > 0) begin
                chk({tg, " done_lat"}, done_cyc - last_en, LAT + 1);
                chk({tg, " done_with_last_sym"}, done_cyc, last_valid);
            end
        end

        // start while busy is ignored, then reset aborts mid-run
        bram_wr_done = 1'b1;
        rate_div = 8'd0;
        loop_en = 1'b0;
        gap_exp = 1;
        clear_mon();
        pulse_start();
        repeat (20) @(negedge clk);
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("busy start addr_err", addr_err, 0);
        chk("busy start en_cnt", en_cnt, 32);
        chk("busy start addr_a", int'(ram_addr_a), 31);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rst viol", rst_viol, 0);
        chk("post rst done", done_cnt, 0);
        chk("post rst valid", valid_cnt, 0);
        chk("post rst busy", int'(busy), 0);

        clear_mon();
        pulse_start();
        repeat (5) @(negedge clk);
        #1;
        chk("restart addr_a", int'(ram_addr_a), 5);
        chk("restart addr_err", addr_err, 0);
        @(negedge clk);
        play_stop = 1'b1;
        @(negedge clk);
        play_stop = 1'b0;
        wait_ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                wait_ok = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        #1;
        chk("restart done seen", wait_ok, 1);
        chk("restart en_cnt", en_cnt, 7);
        chk("restart valid_cnt", valid_cnt, 7);
        chk("restart done_cnt", done_cnt, 1);
        chk("restart lat_err", lat_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
